// File: rtl/tdp_wr_packer.sv
// Packs a 32-bit beat stream into 256-bit words and writes them to consecutive
// addresses of the dual-port RAM A port, wrapping within DEPTH words.
module tdp_wr_packer #(
    parameter int DATA_W = 256,
    parameter int BEAT_W = 32,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_words
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
    logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
    logic [DATA_W-1:0] lane_q, lane_d;
    logic              lastFlag_q, lastFlag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [ADDR_W-1:0] frameWords_q, frameWords_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            wordCnt_q    <= '0;
            beatCnt_q    <= '0;
            lane_q       <= '0;
            lastFlag_q   <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            frameWords_q <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            wordCnt_q    <= wordCnt_d;
            beatCnt_q    <= beatCnt_d;
            lane_q       <= lane_d;
            lastFlag_q   <= lastFlag_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            frameWords_q <= frameWords_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        wordCnt_d    = wordCnt_q;
        beatCnt_d    = beatCnt_q;
        lane_d       = lane_q;
        lastFlag_d   = lastFlag_q;
        addr_d       = addr_q;
        din_d        = din_q;
        frameWords_d = frameWords_q;
        case (state_q)
            IDLE: begin
                // First beat of a frame: an out-of-range base restarts at word 0.
                if (s_valid) begin
                    wptr_d                = (cfg_base > LAST_ADDR) ? '0 : cfg_base;
                    wordCnt_d             = '0;
                    lane_d                = '0;
                    lane_d[BEAT_W-1:0]    = s_data;
                    beatCnt_d             = CNT_W'(1);
                    lastFlag_d            = s_last;
                    state_d               = s_last ? WRITE : PACK;
                end
            end
            PACK: begin
                if (s_valid) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beatCnt_q == CNT_W'(k)) begin
                            lane_d[k*BEAT_W +: BEAT_W] = s_data;
                        end
                    end
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (s_last || (beatCnt_q == LAST_BEAT)) begin
                        lastFlag_d = s_last;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                // Capture what was written so addr/din hold while we is low.
                addr_d    = wptr_q;
                din_d     = lane_q;
                wptr_d    = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_W'(1);
                wordCnt_d = wordCnt_q + ADDR_W'(1);
                lane_d    = '0;
                beatCnt_d = '0;
                if (lastFlag_q) begin
                    frameWords_d = wordCnt_q + ADDR_W'(1);
                    state_d      = DONE;
                end else begin
                    state_d = PACK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready     = rst_n && ((state_q == IDLE) || (state_q == PACK));
        we          = (state_q == WRITE);
        addr        = (state_q == WRITE) ? wptr_q : addr_q;
        din         = (state_q == WRITE) ? lane_q : din_q;
        frame_done  = (state_q == DONE);
        frame_words = frameWords_q;
    end

endmodule

// File: tb/tb_tdp_wr_packer.sv
// Randomized self-checking bench for tdp_wr_packer: a frame-level model predicts
// every RAM write (address, packed data, cycle) and every frame completion.
module tb_tdp_wr_packer;

    localparam int DEPTH = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   cfg_base = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic         we;
    logic [3:0]   addr;
    logic [255:0] din;
    logic         frame_done;
    logic [3:0]   frame_words;

    typedef struct {
        logic [3:0]   addr;
        logic [255:0] din;
        int           cyc;
    } wr_t;

    typedef struct {
        int words;
        int cyc;
    } done_t;

    wr_t          expW[$];
    done_t        expDone[$];
    logic [255:0] obsDin[$];
    logic [255:0] refDin[$];
    logic [31:0]  beatData[0:255];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    tdp_wr_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_base   (cfg_base),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .frame_done (frame_done),
        .frame_words(frame_words)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observes the RAM port each cycle and retires predicted writes and frame ends.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("s_ready", 256'(s_ready), 256'(!(we || frame_done)));
            if (we) begin
                if (expW.size() == 0) begin
                    checkOutput("unexpected_we", 256'(we), 256'(0));
                end else begin
                    wr_t e;
                    e = expW.pop_front();
                    checkOutput("wr_addr", 256'(addr), 256'(e.addr));
                    checkOutput("wr_din", din, e.din);
                    checkOutput("wr_cycle", 256'(cyc), 256'(e.cyc));
                    obsDin.push_back(din);
                end
            end
            if (frame_done) begin
                if (expDone.size() == 0) begin
                    checkOutput("unexpected_done", 256'(frame_done), 256'(0));
                end else begin
                    done_t d;
                    d = expDone.pop_front();
                    checkOutput("frame_words", 256'(frame_words), 256'(d.words));
                    checkOutput("done_cycle", 256'(cyc), 256'(d.cyc));
                end
            end
        end
    end

    // Sends beatData[0..n-1] as one frame; abortAt>0 stops after that many beats.
    task automatic applyStimulus(input logic [3:0] base, input int n, input bit stall, input int abortAt);
        int j = 0;
        int wi = 0;
        int guard = 0;
        int ptr0;
        logic [255:0] word = '0;
        ptr0 = (int'(base) < DEPTH) ? int'(base) : 0;
        cfg_base = base;
        while (j < n && !(abortAt > 0 && j == abortAt)) begin
            @(negedge clk);
            s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = beatData[j];
            s_last  = (abortAt == 0) && (j == n - 1);
            if (s_valid && s_ready) begin
                word[(j % 8) * 32 +: 32] = beatData[j];
                if (abortAt == 0 && ((j % 8) == 7 || j == n - 1)) begin
                    wr_t e;
                    e.addr = 4'((ptr0 + wi) % DEPTH);
                    e.din  = word;
                    e.cyc  = cyc + 1;
                    expW.push_back(e);
                    wi++;
                    word = '0;
                end
                if (abortAt == 0 && j == n - 1) begin
                    done_t d;
                    d.words = wi % 16;
                    d.cyc   = cyc + 2;
                    expDone.push_back(d);
                end
                j++;
                guard = 0;
            end else begin
                guard++;
                if (guard > 50) begin
                    checkOutput("accept_timeout", 256'(guard), 256'(0));
                    break;
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (abortAt == 0) begin
            repeat (3) @(negedge clk);
            checkOutput("pending_wr", 256'(expW.size()), 256'(0));
            checkOutput("pending_done", 256'(expDone.size()), 256'(0));
            checkOutput("words_hold", 256'(frame_words), 256'(wi % 16));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"}, 256'(we), 256'(0));
        checkOutput({tag, "_addr"}, 256'(addr), 256'(0));
        checkOutput({tag, "_din"}, din, 256'(0));
        checkOutput({tag, "_ready"}, 256'(s_ready), 256'(0));
        checkOutput({tag, "_done"}, 256'(frame_done), 256'(0));
        checkOutput({tag, "_words"}, 256'(frame_words), 256'(0));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [255:0] shortExp;
        logic [255:0] singleExp;

        #1;
        checkResetOutputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) beatData[i] = 32'(i);
        applyStimulus(4'd0, 8, 1'b0, 0);

        for (int i = 0; i < 24; i++) beatData[i] = $urandom;
        applyStimulus(4'd8, 24, 1'b0, 0);

        beatData[0] = 32'hA;
        beatData[1] = 32'hB;
        beatData[2] = 32'hC;
        applyStimulus(4'd3, 3, 1'b0, 0);
        shortExp = {160'b0, 32'hC, 32'hB, 32'hA};
        checkOutput("short_din", obsDin[obsDin.size() - 1], shortExp);

        beatData[0] = 32'hFFFF_FFFF;
        applyStimulus(4'd6, 1, 1'b0, 0);
        singleExp = {224'b0, 32'hFFFF_FFFF};
        checkOutput("single_din", obsDin[obsDin.size() - 1], singleExp);

        for (int i = 0; i < 8; i++) beatData[i] = $urandom;
        applyStimulus(4'd5, 8, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beatData[i] = 32'h5A00_0000 | 32'(i);
        applyStimulus(4'd5, 8, 1'b0, 0);

        for (int i = 0; i < 8; i++) beatData[i] = $urandom;
        applyStimulus(4'd12, 8, 1'b0, 0);
        checkOutput("oob_addr", 256'(addr), 256'(0));

        for (int i = 0; i < 16; i++) beatData[i] = $urandom;
        obsDin.delete();
        applyStimulus(4'd2, 16, 1'b0, 0);
        refDin = obsDin;
        obsDin.delete();
        applyStimulus(4'd2, 16, 1'b1, 0);
        checkOutput("stall_count", 256'(obsDin.size()), 256'(refDin.size()));
        for (int i = 0; i < refDin.size() && i < obsDin.size(); i++) begin
            checkOutput("stall_din", obsDin[i], refDin[i]);
        end

        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(1, 90);
            for (int i = 0; i < n; i++) beatData[i] = $urandom;
            applyStimulus(4'($urandom_range(0, 15)), n, 1'($urandom_range(0, 1)), 0);
        end

        for (int i = 0; i < 130; i++) beatData[i] = $urandom;
        applyStimulus(4'd7, 130, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdp_wr_packer.md
Name: tdp_wr_packer

Overview:
Write-side packer that sits directly upstream of the 256-bit x 10-word true-dual-port RAM and drives its A write port.
It accepts a 32-bit valid/ready beat stream and packs 8 beats into one 256-bit word.
It issues a single-cycle write per packed word to consecutive RAM addresses, wrapping within the 10-word depth.
Frames are delimited by s_last; it reports frame completion and the number of words written.

Parameters:
DATA_W, 256, RAM word width (must equal BEAT_W * BEATS)
BEAT_W, 32, input beat width
BEATS, 8, beats per RAM word
ADDR_W, 4, RAM address width
DEPTH, 10, RAM word count; address wraps DEPTH-1 -> 0

Ports:
clk  input  1  single clock; all state on posedge
rst_n  input  1  asynchronous active-low reset
cfg_base  input  ADDR_W  start address of the next frame; sampled on the first beat of each frame
s_valid  input  1  input beat valid
s_ready  output  1  packer can accept a beat
s_data  input  BEAT_W  beat payload
s_last  input  1  final beat of frame; qualified by s_valid
we  output  1  RAM write enable (to weA)
addr  output  ADDR_W  RAM write address (to addrA)
din  output  DATA_W  RAM write data (to dinA)
frame_done  output  1  one-cycle pulse after the last word of a frame is written
frame_words  output  ADDR_W  words written in the last completed frame; holds until the next frame_done

Behaviour:
- Reset (rst_n low, async): state IDLE; we=0, addr=0, din=0, s_ready=0 while rst_n low; frame_done=0, frame_words=0; beat counter and word counter cleared; any partial word is discarded and no write is issued.
- Beat accept: s_valid & s_ready on posedge. Beat k (0..7) of a word lands in bits [BEAT_W*k +: BEAT_W]. Unfilled lanes of a short word are 0.
- States: IDLE, PACK, WRITE, DONE.
- IDLE: s_ready=1. On accept, load the write pointer from cfg_base (values >= DEPTH are treated as 0). Store beat 0, clear the word counter, go to PACK. If that beat has s_last, go to WRITE instead.
- PACK: s_ready=1. Accept beats into successive lanes. On the 8th beat, or on any beat with s_last, go to WRITE and latch a last flag equal to s_last.
- WRITE: exactly one cycle with s_ready=0, we=1, addr=write pointer, din=packed word.
  - Next cycle: we=0; write pointer increments (9 -> 0 wrap, never 10..15); word counter increments; lane buffer and beat counter clear.
  - If the last flag is set, go to DONE; otherwise go to PACK.
- DONE: one cycle. frame_done=1, frame_words=word count (the count wraps modulo 16; frames over 15 words report mod 16). s_ready=0. Go to IDLE.
- Latency: we asserts the cycle after the accept of the word-completing beat.
- Throughput: sustained 8 beats per 9 cycles. Frame-to-frame gap: 1 DONE cycle plus 1 WRITE cycle.
- addr and din hold their last written values while we=0. The RAM must ignore them when we=0.
- s_last on the 8th beat produces exactly one write, not an extra empty word.
- A frame longer than DEPTH words overwrites from the wrapped address; there is no error flag.
- s_data and s_last are ignored when s_ready=0.

Test Plan:
- Reset then cfg_base=0; 8 beats 0x0..0x7 with s_last on beat 7. Required: one we pulse, addr=0, din={32'h7,...,32'h0}. frame_done pulses 2 cycles after the last accept; frame_words=1.
- cfg_base=8; 24 beats back-to-back (s_valid held high), s_last on beat 23. Required: writes to addr 8, 9, 0 (wrap). s_ready low exactly in each WRITE and DONE cycle; frame_words=3.
- Short frame: cfg_base=3; 3 beats 0xA, 0xB, 0xC with s_last on the third. Required: one write to addr 3, din[95:0]={C,B,A}, din[255:96]=0; frame_words=1.
- Single-beat frame: s_last on the first beat 0xFFFFFFFF. Required: write with din[31:0]=FFFFFFFF and the rest 0; frame_done follows.
- rst_n dropped asynchronously after 5 beats of a word. Required: outputs are immediately at reset values and no we occurs. A new 8-beat frame afterwards writes to cfg_base with only new data.
- cfg_base=12 (out of range) with 1 full word. Required: write to addr 0. Stall test: random s_valid gaps must give identical din packing to the gap-free run.
